// File: rtl/serial_word_rx.sv
// serial_word_rx: framed serial-to-parallel receiver (sin/sin_valid/sof/dir in, dout/dout_valid/dout_ready handshake, busy/frame_err/overrun status)
module serial_word_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  input  logic             dir,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, dout_q, dout_d, ld, shf;
  logic dir_q, dir_d, dv_q, dv_d, fe_q, fe_d, ov_q, ov_d, take, step, done;
  always_comb begin
    ld = dir ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};
    shf = dir_q ? {sh_q[WIDTH-2:0], sin} : {sin, sh_q[WIDTH-1:1]};
    take = sin_valid && sof;
    step = sin_valid && !sof && state_q == SHIFT;
    done = step && cnt_q == CW'(WIDTH - 1);
    state_d = take ? SHIFT : done ? IDLE : state_q;
    cnt_d = take ? CW'(1) : done ? '0 : step ? cnt_q + CW'(1) : cnt_q;
    sh_d = take ? ld : step ? shf : sh_q;
    dir_d = take ? dir : dir_q;
    fe_d = sin_valid && ((state_q == SHIFT) == sof);
    ov_d = done && dv_q && !dout_ready;
    dv_d = done || (dv_q && !dout_ready);
    dout_d = (done && !ov_d) ? shf : dout_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      dir_q <= 1'b0;
      dout_q <= '0;
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      dir_q <= dir_d;
      dout_q <= dout_d;
      dv_q <= dv_d;
      fe_q <= fe_d;
      ov_q <= ov_d;
    end
  end
  assign dout = dout_q;
  assign dout_valid = dv_q;
  assign busy = state_q == SHIFT;
  assign frame_err = fe_q;
  assign overrun = ov_q;
endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: randomized and directed checks of serial_word_rx against a queue-based word model
module tb_serial_word_rx;
  localparam int W = 4;
  logic clk = 0, reset_n = 0, sin = 0, sin_valid = 0, sof = 0, dir = 0, dout_ready = 0;
  logic [W-1:0] dout;
  logic dout_valid, busy, frame_err, overrun;
  int nchk = 0, nerr = 0;
  bit q[$];
  bit m_dir, m_v, m_fe, m_ov;
  logic [W-1:0] m_dout;

  serial_word_rx #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid), .sof(sof), .dir(dir),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [W+3:0] model_vec();
    return {m_dout, m_v, q.size() > 0, m_fe, m_ov};
  endfunction

  task automatic model_reset();
    q.delete();
    m_dir = 0; m_v = 0; m_fe = 0; m_ov = 0; m_dout = '0;
  endtask

  task automatic cyc(input bit v, input bit s, input bit f, input bit d, input bit r);
    logic [W-1:0] w;
    sin_valid = v; sin = s; sof = f; dir = d; dout_ready = r;
    @(posedge clk);
    m_fe = 0; m_ov = 0;
    if (v && f) begin
      if (q.size() > 0) m_fe = 1;
      q.delete();
      q.push_back(s);
      m_dir = d;
    end else if (v && q.size() == 0) m_fe = 1;
    else if (v) q.push_back(s);
    if (q.size() == W) begin
      w = '0;
      for (int i = 0; i < W; i++)
        if (q[i]) w = w | (m_dir ? (W'(1) << (W - 1 - i)) : (W'(1) << i));
      q.delete();
      if (m_v && !r) m_ov = 1;
      else begin m_dout = w; m_v = 1; end
    end else if (m_v && r) m_v = 0;
    #1;
  endtask

  task automatic word(input logic [W-1:0] b, input bit d, input int gap, input bit r);
    for (int i = 0; i < W; i++) begin
      if (i > 0) repeat (gap) cyc(0, 0, 0, 0, r);
      cyc(1, b[W-1-i], i == 0, d, r);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    #12;
    nchk++;
    if ({dout, dout_valid, busy, frame_err, overrun} !== '0) begin
      nerr++; $display("FAIL reset_state got %b exp 0", {dout, dout_valid, busy, frame_err, overrun});
    end
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_msb_first();
    logic [W-1:0] b = 4'b1011;
    for (int i = 0; i < W; i++) begin
      cyc(1, b[W-1-i], i == 0, 1, 0);
      nchk++;
      if (busy !== (i < W - 1)) begin
        nerr++; $display("FAIL msb_busy bit%0d got %b exp %b", i, busy, i < W - 1);
      end
    end
    nchk++;
    if (dout !== 4'b1011 || dout_valid !== 1) begin
      nerr++; $display("FAIL msb_word got %b/%b exp 1011/1", dout, dout_valid);
    end
    cyc(0, 0, 0, 0, 1);
    nchk++;
    if (dout_valid !== 0 || dout !== 4'b1011) begin
      nerr++; $display("FAIL msb_consume got %b/%b exp 1011/0", dout, dout_valid);
    end
  endtask

  task automatic test_lsb_first();
    word(4'b1011, 0, 0, 1);
    nchk++;
    if (dout !== 4'b1101 || dout_valid !== 1) begin
      nerr++; $display("FAIL lsb_word got %b/%b exp 1101/1", dout, dout_valid);
    end
    cyc(0, 0, 0, 0, 1);
    nchk++;
    if (dout_valid !== 0) begin
      nerr++; $display("FAIL lsb_one_cycle got %b exp 0", dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    word(4'b0110, 1, 3, 1);
    nchk++;
    if (dout !== 4'b0110 || dout_valid !== 1 || frame_err !== 0) begin
      nerr++; $display("FAIL gap_word got %b/%b/%b exp 0110/1/0", dout, dout_valid, frame_err);
    end
    word(4'b1111, 1, 0, 1);
    nchk++;
    if (dout !== 4'b1111 || dout_valid !== 1 || frame_err !== 0 || overrun !== 0) begin
      nerr++; $display("FAIL b2b_word got %b/%b/%b/%b exp 1111/1/0/0", dout, dout_valid, frame_err, overrun);
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_overrun();
    word(4'b1001, 1, 0, 0);
    nchk++;
    if (overrun !== 0 || dout !== 4'b1001) begin
      nerr++; $display("FAIL ovr_first got %b/%b exp 1001/0", dout, overrun);
    end
    word(4'b0111, 1, 0, 0);
    nchk++;
    if (overrun !== 1 || dout !== 4'b1001 || dout_valid !== 1) begin
      nerr++; $display("FAIL ovr_pulse got %b/%b/%b exp 1001/1/1", dout, dout_valid, overrun);
    end
    cyc(0, 0, 0, 0, 0);
    nchk++;
    if (overrun !== 0 || dout !== 4'b1001 || dout_valid !== 1) begin
      nerr++; $display("FAIL ovr_hold got %b/%b/%b exp 1001/1/0", dout, dout_valid, overrun);
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_frame_err();
    cyc(1, 1, 1, 1, 1);
    cyc(1, 1, 0, 1, 1);
    cyc(1, 0, 1, 1, 1);
    nchk++;
    if (frame_err !== 1 || busy !== 1) begin
      nerr++; $display("FAIL fe_restart got fe=%b busy=%b exp 1/1", frame_err, busy);
    end
    cyc(1, 0, 0, 1, 1);
    nchk++;
    if (frame_err !== 0) begin
      nerr++; $display("FAIL fe_single got %b exp 0", frame_err);
    end
    cyc(1, 1, 0, 1, 1);
    cyc(1, 0, 0, 1, 1);
    nchk++;
    if (dout !== 4'b0010 || dout_valid !== 1) begin
      nerr++; $display("FAIL fe_word got %b/%b exp 0010/1", dout, dout_valid);
    end
    cyc(1, 1, 0, 0, 1);
    nchk++;
    if (frame_err !== 1 || busy !== 0) begin
      nerr++; $display("FAIL fe_stray got fe=%b busy=%b exp 1/0", frame_err, busy);
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_midword();
    word(4'b0101, 1, 0, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 0, 1, 0);
    reset_n = 0;
    model_reset();
    #1;
    nchk++;
    if ({dout, dout_valid, busy, frame_err, overrun} !== '0) begin
      nerr++; $display("FAIL async_reset got %b exp 0", {dout, dout_valid, busy, frame_err, overrun});
    end
    @(negedge clk);
    reset_n = 1;
    word(4'b1000, 1, 0, 0);
    nchk++;
    if (dout !== 4'b1000 || dout_valid !== 1 || frame_err !== 0) begin
      nerr++; $display("FAIL post_reset got %b/%b/%b exp 1000/1/0", dout, dout_valid, frame_err);
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(9) < 7, $urandom_range(1), $urandom_range(9) == 0,
          $urandom_range(1), $urandom_range(2) != 0);
      nchk++;
      if ({dout, dout_valid, busy, frame_err, overrun} !== model_vec()) begin
        nerr++;
        $display("FAIL rand cyc%0d got {dout,v,busy,fe,ov}=%b exp %b", n,
                 {dout, dout_valid, busy, frame_err, overrun}, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_midword();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
